lock_code_fsm: RTL

Code-entry state machine for the digital lock. Sits directly downstream of the per-button `buttonMonitor` instances. It consumes their single-cycle `buttonEdge` pulses as digit entries and compares the entered sequence against a parameterised passcode. It then drives the lock/unlock/error indications to the display and actuator logic.

---
 rtl/lock_code_fsm.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/lock_code_fsm.sv
// Code-entry FSM for the digital lock: checks buttonEdge digit presses against PASSCODE.
// Optional lockout after repeated failures is compiled in with `define LOCK_LOCKOUT_EN.
module lock_code_fsm #(
    parameter int                         CODE_LENGTH    = 4,
    parameter logic [2*CODE_LENGTH-1:0]   PASSCODE       = 8'hE4,
    parameter logic [23:0]                UNLOCK_CYCLES  = 24'd5_000_000,
    parameter logic [23:0]                ERROR_CYCLES   = 24'd2_500_000,
    parameter logic [23:0]                TIMEOUT_CYCLES = 24'd10_000_000,
    parameter int                         MAX_FAILS      = 3,
    parameter logic [23:0]                LOCKOUT_CYCLES = 24'd15_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] buttonEdge,
    output logic       locked,
    output logic       unlocked,
    output logic       error,
    output logic       lockedOut,
    output logic [3:0] digitCount
);

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_ERROR    = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_DIGIT = 4'(CODE_LENGTH - 1);

    state_t      state_reg, state_next;
    logic [23:0] timer_reg, timer_next;
    logic [3:0]  digit_count_reg, digit_count_next;
    logic        mismatch_reg, mismatch_next;
    logic        locked_reg, locked_next;
    logic        unlocked_reg, unlocked_next;
    logic        error_reg, error_next;

    // Unpack the passcode into a 16-entry table so any 4-bit digit count indexes it safely.
    logic [1:0] code_digit [16];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_code
            if (gi < CODE_LENGTH) begin : g_used
                assign code_digit[gi] = PASSCODE[2*gi +: 2];
            end else begin : g_pad
                assign code_digit[gi] = 2'b00;
            end
        end
    endgenerate

    logic       press;
    logic       single_press;
    logic [1:0] press_idx;
    logic       digit_ok;
    logic       last_digit;

    assign press        = |buttonEdge;
    assign single_press = press && ((buttonEdge & (buttonEdge - 4'd1)) == 4'd0);
    assign last_digit   = (digit_count_reg == LAST_DIGIT);

    always_comb begin
        press_idx = 2'd0;
        case (buttonEdge)
            4'b0010: press_idx = 2'd1;
            4'b0100: press_idx = 2'd2;
            4'b1000: press_idx = 2'd3;
            default: press_idx = 2'd0;
        endcase
    end

    // A multi-bit press still consumes a digit slot but can never match.
    assign digit_ok = single_press && (press_idx == code_digit[digit_count_reg]);

`ifdef LOCK_LOCKOUT_EN
    localparam logic [7:0] FAIL_MAX = 8'(MAX_FAILS);
    logic [7:0] fail_count_reg, fail_count_next;
    logic       lockedout_reg, lockedout_next;
`else
    if (MAX_FAILS < 0 && LOCKOUT_CYCLES == 24'd0) begin : g_lockout_params_ignored
    end
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_ENTRY;
            timer_reg       <= 24'd0;
            digit_count_reg <= 4'd0;
            mismatch_reg    <= 1'b0;
            locked_reg      <= 1'b1;
            unlocked_reg    <= 1'b0;
            error_reg       <= 1'b0;
`ifdef LOCK_LOCKOUT_EN
            fail_count_reg  <= 8'd0;
            lockedout_reg   <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            digit_count_reg <= digit_count_next;
            mismatch_reg    <= mismatch_next;
            locked_reg      <= locked_next;
            unlocked_reg    <= unlocked_next;
            error_reg       <= error_next;
`ifdef LOCK_LOCKOUT_EN
            fail_count_reg  <= fail_count_next;
            lockedout_reg   <= lockedout_next;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_next       = state_reg;
        timer_next       = timer_reg;
        digit_count_next = digit_count_reg;
        mismatch_next    = mismatch_reg;
`ifdef LOCK_LOCKOUT_EN
        fail_count_next  = fail_count_reg;
`endif
        case (state_reg)
            ST_ENTRY: begin
                if (press) begin
                    if (last_digit) begin
                        digit_count_next = 4'd0;
                        mismatch_next    = 1'b0;
                        if (mismatch_reg || !digit_ok) begin
                            state_next = ST_ERROR;
                            timer_next = ERROR_CYCLES - 24'd1;
`ifdef LOCK_LOCKOUT_EN
                            if (fail_count_reg < FAIL_MAX)
                                fail_count_next = fail_count_reg + 8'd1;
`endif
                        end else begin
                            state_next = ST_UNLOCKED;
                            timer_next = UNLOCK_CYCLES - 24'd1;
`ifdef LOCK_LOCKOUT_EN
                            fail_count_next = 8'd0;
`endif
                        end
                    end else begin
                        digit_count_next = digit_count_reg + 4'd1;
                        mismatch_next    = mismatch_reg | ~digit_ok;
                        timer_next       = TIMEOUT_CYCLES - 24'd1;
                    end
                end else if (digit_count_reg != 4'd0) begin
                    // Idle timer only runs while a partial entry is pending.
                    if (timer_reg == 24'd0) begin
                        digit_count_next = 4'd0;
                        mismatch_next    = 1'b0;
                    end else begin
                        timer_next = timer_reg - 24'd1;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (press || timer_reg == 24'd0) begin
                    state_next = ST_ENTRY;
                    timer_next = TIMEOUT_CYCLES - 24'd1;
                end else begin
                    timer_next = timer_reg - 24'd1;
                end
            end
            ST_ERROR: begin
                if (timer_reg == 24'd0) begin
`ifdef LOCK_LOCKOUT_EN
                    if (fail_count_reg == FAIL_MAX) begin
                        state_next = ST_LOCKOUT;
                        timer_next = LOCKOUT_CYCLES - 24'd1;
                    end else begin
                        state_next = ST_ENTRY;
                        timer_next = TIMEOUT_CYCLES - 24'd1;
                    end
`else
                    state_next = ST_ENTRY;
                    timer_next = TIMEOUT_CYCLES - 24'd1;
`endif
                end else begin
                    timer_next = timer_reg - 24'd1;
                end
            end
`ifdef LOCK_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (timer_reg == 24'd0) begin
                    state_next      = ST_ENTRY;
                    timer_next      = TIMEOUT_CYCLES - 24'd1;
                    fail_count_next = 8'd0;
                end else begin
                    timer_next = timer_reg - 24'd1;
                end
            end
`endif
            default: begin
                state_next       = ST_ENTRY;
                digit_count_next = 4'd0;
                mismatch_next    = 1'b0;
            end
        endcase
    end

    // Output logic: decoded from the next state so the outputs land in registers.
    always_comb begin
        locked_next   = (state_next != ST_UNLOCKED);
        unlocked_next = (state_next == ST_UNLOCKED);
        error_next    = (state_next == ST_ERROR);
`ifdef LOCK_LOCKOUT_EN
        lockedout_next = (state_next == ST_LOCKOUT);
`endif
    end

    assign locked     = locked_reg;
    assign unlocked   = unlocked_reg;
    assign error      = error_reg;
    assign digitCount = digit_count_reg;
`ifdef LOCK_LOCKOUT_EN
    assign lockedOut  = lockedout_reg;
`else
    assign lockedOut  = 1'b0;
`endif

endmodule
